// File: rtl/vga_scan_out.sv
// VGA raster scan-out: clock divider, h/v counters driving pixel coordinates,
// and a one-pixel-delayed stage producing RGB332 DAC drive, syncs and a frame strobe.
module vga_scan_out #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2
) (
  input  logic       CLK_IN,
  input  logic       RST_IN,
  input  logic [7:0] memRGB,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       FRAME_CLOCK,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic [2:0] RED,
  output logic [2:0] GREEN,
  output logic [1:0] BLUE
);

  localparam int HT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(HT - 1);
  localparam logic [9:0] V_LAST   = 10'(VT - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_en;
  logic [9:0]       hcount_q, hcount_d;
  logic [9:0]       vcount_q, vcount_d;
  logic [7:0]       rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             frame_q, frame_d;
  logic             visible;

  // With CLK_DIV=1 the divider is a constant zero, so pix_en is held high.
  assign pix_en  = (div_q == DIV_LAST);
  assign visible = (hcount_q < H_VIS) && (vcount_q < V_VIS);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    div_d    = div_q;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    rgb_d    = rgb_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    frame_d  = frame_q;

    if (pix_en) begin
      div_d = '0;
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 10'd1;
      end

      // Stage 2 works on the coordinates currently presented, so it lags x,y by one pixel.
      rgb_d   = visible ? memRGB : 8'h00;
      hsync_d = !((hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST));
      vsync_d = !((vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST));
      frame_d = (hcount_q == 10'd0) && (vcount_q == V_VIS);
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      div_q    <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
      rgb_q    <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      frame_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      div_q    <= div_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      rgb_q    <= rgb_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      frame_q  <= frame_d;
    end
  end

  assign x           = hcount_q;
  assign y           = vcount_q;
  assign RED         = rgb_q[7:5];
  assign GREEN       = rgb_q[4:2];
  assign BLUE        = rgb_q[1:0];
  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign FRAME_CLOCK = frame_q;

endmodule
